// File: rtl/fir_decim_dump_if.sv
// Handshake and status bundle between the FIR-side producer, the
// integrate-and-dump decimator and the downstream consumer.
interface fir_decim_dump_if;
  logic               clear;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               sat;
  logic               overflow;
  logic [3:0]         level;

  // Driver side: feeds samples and consumes results.
  modport master (
    output clear, in_valid, in_data, out_ready,
    input  out_valid, out_data, sat, overflow, level
  );

  // Decimator side.
  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output out_valid, out_data, sat, overflow, level
  );
endinterface

// File: rtl/fir_decim_dump.sv
// Integrate-and-dump decimator: sums DECIM valid FIR samples, shifts and
// saturates the block sum, and queues results in a small FIFO read out
// through a valid/ready handshake. All outputs come straight from flops.
module fir_decim_dump #(
  parameter int DECIM      = 4,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  fir_decim_dump_if.slave  bus
);

  localparam int         PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] LAST_PHASE = 4'(DECIM - 1);
  localparam logic [3:0] DEPTH_L    = 4'(FIFO_DEPTH);

  // Clamp a 20-bit value into 16-bit signed range; bit 16 flags clamping.
  function automatic logic [16:0] sat16(input logic signed [19:0] v);
    logic [16:0] r;
    if (v > 20'sh0_7FFF) begin
      r = {1'b1, 16'h7FFF};
    end else if (v < 20'shF_8000) begin
      r = {1'b1, 16'h8000};
    end else begin
      r = {1'b0, v[15:0]};
    end
    return r;
  endfunction

  logic signed [19:0] acc_r;
  logic [3:0]         phase_r;
  logic [15:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [3:0]         count_r;
  logic               out_valid_r;
  logic [15:0]        out_data_r;
  logic               sat_r;
  logic               overflow_r;

  logic signed [19:0] din_ext_s;
  logic signed [19:0] sum_s;
  logic signed [19:0] shifted_s;
  logic [16:0]        sat_res_s;
  logic               dump_s;
  logic               pop_s;
  logic               full_s;
  logic               push_s;
  logic               drop_s;
  logic [3:0]         count_nx_s;
  logic [PTR_W-1:0]   rd_nx_s;
  logic [15:0]        head_nx_s;

  assign din_ext_s = {{4{bus.in_data[15]}}, bus.in_data};
  assign sum_s     = acc_r + din_ext_s;
  assign shifted_s = sum_s >>> SHIFT;
  assign sat_res_s = sat16(shifted_s);

  assign dump_s = bus.in_valid && !bus.clear && (phase_r == LAST_PHASE);
  assign pop_s  = out_valid_r && bus.out_ready;
  assign full_s = (count_r == DEPTH_L);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_s = dump_s && (!full_s || pop_s);
  assign drop_s = dump_s && full_s && !pop_s;

  // Next occupancy, read pointer and head word, with write-through when the
  // freshly pushed result becomes the head.
  always_comb begin
    count_nx_s = count_r;
    rd_nx_s    = rd_ptr_r;
    head_nx_s  = 16'h0000;
    if (push_s && !pop_s) begin
      count_nx_s = count_r + 4'd1;
    end else if (!push_s && pop_s) begin
      count_nx_s = count_r - 4'd1;
    end else begin
      count_nx_s = count_r;
    end
    if (pop_s) begin
      rd_nx_s = rd_ptr_r + PTR_W'(1'b1);
    end else begin
      rd_nx_s = rd_ptr_r;
    end
    if (count_nx_s == 4'd0) begin
      head_nx_s = 16'h0000;
    end else if (push_s && (rd_nx_s == wr_ptr_r)) begin
      head_nx_s = sat_res_s[15:0];
    end else begin
      head_nx_s = mem_r[rd_nx_s];
    end
  end

  // Accumulator and phase: clear wins over a sample, dump restarts the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= 20'sd0;
      phase_r <= 4'd0;
    end else if (bus.clear) begin
      acc_r   <= 20'sd0;
      phase_r <= 4'd0;
    end else if (bus.in_valid) begin
      if (phase_r == LAST_PHASE) begin
        acc_r   <= 20'sd0;
        phase_r <= 4'd0;
      end else begin
        acc_r   <= sum_s;
        phase_r <= phase_r + 4'd1;
      end
    end
  end

  // FIFO storage; contents are wiped on reset so nothing stale can surface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= sat_res_s[15:0];
    end
  end

  // FIFO pointers, occupancy and registered output port values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= 4'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 16'h0000;
      sat_r       <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      rd_ptr_r    <= rd_nx_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      count_r     <= count_nx_s;
      out_valid_r <= (count_nx_s != 4'd0);
      out_data_r  <= head_nx_s;
      sat_r       <= dump_s && sat_res_s[16];
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.sat       = sat_r;
  assign bus.overflow  = overflow_r;
  assign bus.level     = count_r;

endmodule

// File: tb/tb_fir_decim_dump.sv
// Directed bench: DUT a uses SHIFT=2, DUT b uses SHIFT=0, both share stimulus.
module tb_fir_decim_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  fir_decim_dump_if a_if ();
  fir_decim_dump_if b_if ();

  assign a_if.clear     = clear;
  assign a_if.in_valid  = in_valid;
  assign a_if.in_data   = in_data;
  assign a_if.out_ready = out_ready;
  assign b_if.clear     = clear;
  assign b_if.in_valid  = in_valid;
  assign b_if.in_data   = in_data;
  assign b_if.out_ready = out_ready;

  fir_decim_dump #(.DECIM(4), .SHIFT(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if)
  );
  fir_decim_dump #(.DECIM(4), .SHIFT(0), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        iv;
    logic [15:0] din;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic        es;
    logic [3:0]  el;
    logic [15:0] ebd;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic clr, input logic iv, input logic [15:0] din,
                      input logic rdy, input logic ev, input logic [15:0] ed,
                      input logic es, input logic [3:0] el, input logic [15:0] ebd);
    vec_t v;
    v.clr = clr; v.iv = iv; v.din = din; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.es = es; v.el = el; v.ebd = ebd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs away from the edge, then settle past the edge.
  task automatic step(input logic c, input logic iv, input logic [15:0] d, input logic r);
    clear = c; in_valid = iv; in_data = d; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, a_if.out_valid}, 32'd0);
    chk("rst_data", {16'd0, a_if.out_data}, 32'd0);
    chk("rst_sat", {31'd0, a_if.sat}, 32'd0);
    chk("rst_ovf", {31'd0, a_if.overflow}, 32'd0);
    chk("rst_level", {28'd0, a_if.level}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Basic block, floor of negatives, gapped valid, mixed-sign floor.
    addv(1'b0, 1'b1, 16'd10, 1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd20, 1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd30, 1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd40, 1'b1, 1'b1, 16'd25,  1'b0, 4'd1, 16'd100);
    addv(1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'd0, 1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd0,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd0,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd0,  1'b1, 1'b1, 16'hFFFF, 1'b0, 4'd1, 16'hFFFF);
    addv(1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd1,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b0, 16'd9,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b0, 16'd9,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd2,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd3,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b0, 16'd9,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd4,  1'b1, 1'b1, 16'd2,   1'b0, 4'd1, 16'd10);
    addv(1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'hFFFD, 1'b1, 1'b0, 16'd0, 1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16'd0, 1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd0,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);
    addv(1'b0, 1'b1, 16'd0,  1'b1, 1'b1, 16'hFFFE, 1'b0, 4'd1, 16'hFFFB);
    addv(1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd0,   1'b0, 4'd0, 16'd0);

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].clr, tbl[i].iv, tbl[i].din, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), {31'd0, a_if.out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_data", i), {16'd0, a_if.out_data}, {16'd0, tbl[i].ed});
      chk($sformatf("tbl%0d_sat", i), {31'd0, a_if.sat}, {31'd0, tbl[i].es});
      chk($sformatf("tbl%0d_level", i), {28'd0, a_if.level}, {28'd0, tbl[i].el});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, a_if.overflow}, 32'd0);
      chk($sformatf("tbl%0d_b_valid", i), {31'd0, b_if.out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_b_data", i), {16'd0, b_if.out_data}, {16'd0, tbl[i].ebd});
    end

    // Saturation on the SHIFT=0 instance, both polarities.
    do_reset();
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 16'h7FFF, 1'b1);
    chk("satp_b_data", {16'd0, b_if.out_data}, 32'h7FFF);
    chk("satp_b_sat", {31'd0, b_if.sat}, 32'd1);
    chk("satp_a_data", {16'd0, a_if.out_data}, 32'h7FFF);
    chk("satp_a_sat", {31'd0, a_if.sat}, 32'd0);
    step(1'b0, 1'b0, 16'd0, 1'b1);
    chk("satp_b_sat_end", {31'd0, b_if.sat}, 32'd0);
    chk("satp_b_valid_end", {31'd0, b_if.out_valid}, 32'd0);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 16'h8000, 1'b1);
    chk("satn_b_data", {16'd0, b_if.out_data}, 32'h8000);
    chk("satn_b_sat", {31'd0, b_if.sat}, 32'd1);
    chk("satn_a_data", {16'd0, a_if.out_data}, 32'h8000);
    chk("satn_a_sat", {31'd0, a_if.sat}, 32'd0);
    step(1'b0, 1'b0, 16'd0, 1'b1);

    // Back-pressure: fill, drop the fifth result, then drain in order.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 16'(k * 4), 1'b0);
      if (k == 4) begin
        chk("fill_level", {28'd0, a_if.level}, 32'd4);
        chk("fill_ovf", {31'd0, a_if.overflow}, 32'd0);
      end
    end
    chk("drop_level", {28'd0, a_if.level}, 32'd4);
    chk("drop_ovf", {31'd0, a_if.overflow}, 32'd1);
    chk("drop_head", {16'd0, a_if.out_data}, 32'd4);
    chk("drop_valid", {31'd0, a_if.out_valid}, 32'd1);
    for (int k = 2; k <= 5; k++) begin
      step(1'b0, 1'b0, 16'd0, 1'b1);
      chk($sformatf("drain%0d_data", k), {16'd0, a_if.out_data}, (k <= 4) ? 32'(k * 4) : 32'd0);
      chk($sformatf("drain%0d_level", k), {28'd0, a_if.level}, 32'(5 - k));
    end
    chk("drain_valid", {31'd0, a_if.out_valid}, 32'd0);
    chk("drain_ovf_sticky", {31'd0, a_if.overflow}, 32'd1);

    // Full FIFO: dump and pop on the same edge keeps everything.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 16'(k * 4), 1'b0);
    end
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 16'd20, 1'b0);
    step(1'b0, 1'b1, 16'd20, 1'b1);
    chk("pp_level", {28'd0, a_if.level}, 32'd4);
    chk("pp_ovf", {31'd0, a_if.overflow}, 32'd0);
    chk("pp_head", {16'd0, a_if.out_data}, 32'd8);
    for (int k = 3; k <= 6; k++) begin
      step(1'b0, 1'b0, 16'd0, 1'b1);
      chk($sformatf("pp_drain%0d_data", k), {16'd0, a_if.out_data}, (k <= 5) ? 32'(k * 4) : 32'd0);
      chk($sformatf("pp_drain%0d_level", k), {28'd0, a_if.level}, 32'(6 - k));
    end

    // Reset mid-block discards the partial sum.
    step(1'b0, 1'b1, 16'd100, 1'b1);
    step(1'b0, 1'b1, 16'd100, 1'b1);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mr_level", {28'd0, a_if.level}, 32'd0);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 16'd4, 1'b1);
    chk("mr_no_early", {31'd0, a_if.out_valid}, 32'd0);
    step(1'b0, 1'b1, 16'd4, 1'b1);
    chk("mr_a_data", {16'd0, a_if.out_data}, 32'd4);
    chk("mr_b_data", {16'd0, b_if.out_data}, 32'd16);
    chk("mr_valid", {31'd0, a_if.out_valid}, 32'd1);
    chk("mr_ovf", {31'd0, a_if.overflow}, 32'd0);
    step(1'b0, 1'b0, 16'd0, 1'b1);

    // Clear mid-block with one entry pending: entry kept, new block clean.
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 16'd8, 1'b0);
    chk("cl_pending_level", {28'd0, a_if.level}, 32'd1);
    step(1'b0, 1'b1, 16'd100, 1'b0);
    step(1'b0, 1'b1, 16'd100, 1'b0);
    step(1'b1, 1'b1, 16'd100, 1'b0);
    chk("cl_keep_level", {28'd0, a_if.level}, 32'd1);
    chk("cl_keep_head", {16'd0, a_if.out_data}, 32'd8);
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1, 16'd4, 1'b0);
    chk("cl_level", {28'd0, a_if.level}, 32'd2);
    chk("cl_head", {16'd0, a_if.out_data}, 32'd8);
    step(1'b0, 1'b0, 16'd0, 1'b1);
    chk("cl_new_a", {16'd0, a_if.out_data}, 32'd4);
    chk("cl_new_b", {16'd0, b_if.out_data}, 32'd16);
    chk("cl_new_level", {28'd0, a_if.level}, 32'd1);
    step(1'b0, 1'b0, 16'd0, 1'b1);
    chk("cl_empty_data", {16'd0, a_if.out_data}, 32'd0);
    chk("cl_empty_valid", {31'd0, a_if.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_decim_dump.md
# fir_decim_dump

Integrate-and-dump decimator that sits directly downstream of the transposed-form FIR filter. It accumulates DECIM consecutive valid filter output samples, scales and saturates the sum, and writes each result into a small output FIFO. The FIFO feeds the next stage through a valid/ready handshake, so the block absorbs consumer back-pressure without stalling the filter.

## Interface
- DECIM, 4: decimation ratio. Legal range 2..16.
- SHIFT, 2: arithmetic right shift applied to each block sum. Legal range 0..4.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of two, 2..8.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous; discards the partial accumulation and restarts the phase. FIFO contents are kept.
- in_valid  in  1  in_data carries a filter output sample this cycle. The FIR's valid, delayed one cycle, drives this port.
- in_data  in  16  signed filter output sample.
- out_valid  out  1  FIFO non-empty; out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  16  signed decimated sample at the FIFO head.
- sat  out  1  one-cycle pulse: the result just pushed (or dropped) was saturated.
- overflow  out  1  sticky: a result was dropped because the FIFO was full. Cleared only by rst.
- level  out  4  current FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Accumulator is a signed register of 20 bits (16 + 4 guard bits), so it cannot overflow for DECIM ≤ 16.
- Phase counter runs 0..DECIM-1 and advances only on cycles with in_valid=1. Cycles with in_valid=0 change nothing.
- Accepted sample with phase < DECIM-1:
  - acc <= acc + in_data.
  - phase <= phase + 1.
- Accepted sample with phase = DECIM-1 (dump):
  - sum = acc + in_data, computed at full width.
  - res = sum >>> SHIFT. This is an arithmetic shift that floors toward −∞, so −1 >>> 2 = −1.
  - res is saturated to the range [−32768, 32767]. sat pulses when clamping occurred.
  - The result is pushed to the FIFO.
  - acc <= 0, phase <= 0.
- clear=1 forces acc <= 0 and phase <= 0 and has priority over in_valid in the same cycle. The sample on that cycle is discarded.
- FIFO rules:
  - Push happens on a dump cycle.
  - Pop happens when out_valid & out_ready.
  - Push and pop in the same cycle, including when full, both take effect. level is unchanged and nothing is dropped.
  - Push while full with no pop: the result is dropped, overflow is set, and sat still reflects the dropped result.
  - Pop while empty: no effect.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- out_data shows the head entry when level > 0, and 0 when the FIFO is empty.
- Reset values: acc=0, phase=0, FIFO empty (level=0), out_valid=0, out_data=0, sat=0, overflow=0.
- Reset asserted mid-block discards the partial sum and all FIFO contents. No output appears until a full DECIM-sample block completes after reset is released.

## Timing
- Dump sample accepted on edge t: the result becomes visible on out_data/out_valid after edge t, when the FIFO was empty. sat is high during cycle t+1 only.
- One result per DECIM accepted samples. Throughput is independent of gaps in in_valid.
- Output handshake: data transfers on any edge where out_valid & out_ready. out_data changes to the next entry after that edge.
- out_valid is not withdrawn while out_ready=0. out_data is held stable until it is popped.
- level updates on the same edge as the push/pop that changes it.
- No combinational path from in_* to out_*. out_valid and out_data depend only on registers.

## Test plan
- DECIM=4, SHIFT=2, out_ready=1, inputs 10,20,30,40 -> one result 25 (100>>>2), sat=0, out_valid high for exactly one cycle.
- SHIFT=0, four samples of 32767 -> result 32767, sat pulse. Four samples of −32768 -> result −32768, sat pulse. Inputs −1,0,0,0 with SHIFT=2 -> result −1.
- in_valid toggling 1,0,0,1,1,0,1 with samples 1,2,3,4 -> single result 2 (10>>>2), produced only after the 4th valid sample.
- out_ready=0 and 5 blocks of constant 4·k (k=1..5), SHIFT=2 -> level reaches 4, 5th result dropped, overflow=1. Then raise out_ready -> outputs 4,8,12,16 in order, level returns to 0. On a full FIFO, a dump and a pop on the same cycle -> no drop, level stays 4.
- Two samples into a block, then assert rst for one cycle, then samples 4,4,4,4 -> result 4, no remnant of the earlier partial sum, overflow=0. Repeat using clear instead of rst, with one FIFO entry pending -> the pending entry is preserved and the new block result is correct.
